// File: rtl/digit_scan_ctrl.sv
// Four-digit seven-segment scan controller.
// A prescaler divides clk into REFRESH_DIV-cycle slots. Each slot advances digit_idx
// to the next digit enabled in digit_en. digit_sel is an active-low one-hot anode select.
// Optional feature macro: SCAN_DIMMING_EN adds a 4-bit duty input that lights each digit
// for only the first part of its slot.
module digit_scan_ctrl #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned CW          = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] digit_en,
`ifdef SCAN_DIMMING_EN
  input  logic [3:0] duty,
`endif
  output logic [3:0] digit_sel,
  output logic [1:0] digit_idx,
  output logic       tick
);

  localparam int unsigned TW = CW + 5;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          term;
  logic [1:0]    idx_adv;
  logic [1:0]    idx_next;
  logic          lit;

  // Prescaler terminal count and next-slot search (idx+1, idx+2, idx+3, then idx itself)
  always_comb begin
    logic       found;
    logic [1:0] cand;
    term     = (cnt == CW'(REFRESH_DIV - 1));
    cnt_next = term ? '0 : cnt + CW'(1);
    idx_adv  = digit_idx;
    found    = 1'b0;
    cand     = digit_idx;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = digit_idx + 2'(k);
      if (!found && digit_en[cand]) begin
        idx_adv = cand;
        found   = 1'b1;
      end
    end
    idx_next = term ? idx_adv : digit_idx;
  end

`ifdef SCAN_DIMMING_EN
  logic [TW-1:0] thr_full;
  logic [TW-1:0] thr;

  // Brightness threshold: the digit is lit while the upcoming count is below thr
  always_comb begin
    thr_full = (TW'(duty) + TW'(1)) * TW'(REFRESH_DIV);
    thr      = thr_full >> 4;
    lit      = (TW'(cnt_next) < thr);
  end
`else
  assign lit = 1'b1;
`endif

  // All state and outputs are registered; disabling the scan freezes it and blanks the anodes
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      digit_idx <= 2'd0;
      digit_sel <= 4'b1111;
      tick      <= 1'b0;
    end else if (!en) begin
      tick      <= 1'b0;
      digit_sel <= 4'b1111;
    end else begin
      cnt       <= cnt_next;
      digit_idx <= idx_next;
      tick      <= term;
      digit_sel <= (digit_en[idx_next] && lit) ? ~(4'b0001 << idx_next) : 4'b1111;
    end
  end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Randomized scoreboard bench for digit_scan_ctrl with a slot-level reference model.
module tb_digit_scan_ctrl;

  localparam int RD = 4;

  typedef struct packed {
    logic [3:0] sel;
    logic [1:0] idx;
    logic       tick;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] digit_en;
  logic [3:0] duty;
  logic [3:0] digit_sel;
  logic [1:0] digit_idx;
  logic       tick;

  int checks   = 0;
  int failures = 0;

  exp_t q[$];

  // Reference model state: position within the slot and the current digit
  int m_cnt = 0;
  int m_idx = 0;

  digit_scan_ctrl #(
    .REFRESH_DIV(RD),
    .CW         (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .digit_en (digit_en),
`ifdef SCAN_DIMMING_EN
    .duty     (duty),
`endif
    .digit_sel(digit_sel),
    .digit_idx(digit_idx),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs and queue what the DUT must show after the next edge
  task automatic drive(input logic r, input logic e, input logic [3:0] d, input logic [3:0] du);
    exp_t x;
    int   thr;
    bit   lit_m;
    @(negedge clk);
    rst      = r;
    en       = e;
    digit_en = d;
    duty     = du;
    x.tick   = 1'b0;
    x.sel    = 4'b1111;
    if (r) begin
      m_cnt = 0;
      m_idx = 0;
    end else if (e) begin
      if (m_cnt == RD - 1) begin
        m_cnt  = 0;
        x.tick = 1'b1;
        for (int k = 1; k <= 4; k++) begin
          if (d[(m_idx + k) % 4]) begin
            m_idx = (m_idx + k) % 4;
            break;
          end
        end
      end else begin
        m_cnt = m_cnt + 1;
      end
      thr = ((int'(du) + 1) * RD) / 16;
`ifdef SCAN_DIMMING_EN
      lit_m = (m_cnt < thr);
`else
      lit_m = (thr >= 0);
`endif
      if (d[m_idx] && lit_m) x.sel = 4'b1111 ^ (4'b0001 << m_idx);
    end
    x.idx = 2'(m_idx);
    q.push_back(x);
  endtask

  // Monitor: compare every cycle's registered outputs against the queued expectation
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (digit_sel !== e.sel) begin
        failures++;
        $display("FAIL digit_sel t=%0t got=%b exp=%b", $time, digit_sel, e.sel);
      end
      checks++;
      if (digit_idx !== e.idx) begin
        failures++;
        $display("FAIL digit_idx t=%0t got=%0d exp=%0d", $time, digit_idx, e.idx);
      end
      checks++;
      if (tick !== e.tick) begin
        failures++;
        $display("FAIL tick t=%0t got=%b exp=%b", $time, tick, e.tick);
      end
      checks++;
      if (!(digit_sel == 4'b1111 || $countones(~digit_sel) == 1)) begin
        failures++;
        $display("FAIL sel_shape t=%0t got=%b exp=single-zero-or-ones", $time, digit_sel);
      end
    end
  end

  // Run until the model reaches a given slot position, bounded
  task automatic run_to(input int idx_t, input int cnt_t, input string name);
    int n = 0;
    while (!(m_idx == idx_t && m_cnt == cnt_t) && n < 64) begin
      drive(1'b0, 1'b1, 4'hF, 4'hF);
      n++;
    end
    checks++;
    if (n >= 64) begin
      failures++;
      $display("FAIL %s reach got=idx%0d/cnt%0d exp=idx%0d/cnt%0d", name, m_idx, m_cnt,
               idx_t, cnt_t);
    end
  endtask

  initial begin
    int n;
    logic [3:0] de;
    logic [3:0] du;
    rst = 1'b1; en = 1'b0; digit_en = 4'h0; duty = 4'hF;

    // Reset, then full rotation
    drive(1'b1, 1'b1, 4'hF, 4'hF);
    drive(1'b1, 1'b1, 4'hF, 4'hF);
    repeat (20) drive(1'b0, 1'b1, 4'hF, 4'hF);
    // Alternate digits 0 and 2
    repeat (16) drive(1'b0, 1'b1, 4'b0101, 4'hF);
    // Nothing enabled: blank, idx holds, tick continues
    repeat (12) drive(1'b0, 1'b1, 4'h0, 4'hF);
    // Single digit enabled: idx stays, tick pulses
    repeat (10) drive(1'b0, 1'b1, 4'b1000, 4'hF);
    // Freeze mid-slot, then resume
    run_to(1, 2, "freeze");
    repeat (10) drive(1'b0, 1'b0, 4'hF, 4'hF);
    repeat (6) drive(1'b0, 1'b1, 4'hF, 4'hF);
    // Freeze exactly at terminal count
    run_to(2, 3, "hold_term");
    repeat (3) drive(1'b0, 1'b0, 4'hF, 4'hF);
    repeat (3) drive(1'b0, 1'b1, 4'hF, 4'hF);
    // Mid-slot reset
    run_to(3, 1, "rst_mid");
    drive(1'b1, 1'b1, 4'hF, 4'hF);
    repeat (10) drive(1'b0, 1'b1, 4'hF, 4'hF);
    // Clear the current digit mid-slot
    run_to(1, 1, "clear_cur");
    repeat (6) drive(1'b0, 1'b1, 4'b1101, 4'hF);

    // Randomized traffic
    de = 4'hF;
    du = 4'hF;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) de = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) du = 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) != 0), de, du);
    end

    n = 0;
    while (q.size() != 0 && n < 5) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
